// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter slice:
// port widths, clear FSM states and requester IDs.
package regfile_write_arbiter_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    localparam logic GNT_ALU = 1'b0;
    localparam logic GNT_MEM = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester that did not win
// last time is chosen; last_grant only moves when something is granted.
module rr_arbiter2
    import regfile_write_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic valid0,
    input  logic valid1,
    output logic gnt0,
    output logic gnt1,
    output logic last_grant
);

    logic last_grant_q;
    logic last_grant_d;

    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        last_grant_d = last_grant_q;
        if (en) begin
            if (valid0 && valid1) begin
                gnt0 = (last_grant_q == GNT_MEM);
                gnt1 = (last_grant_q == GNT_ALU);
            end else begin
                gnt0 = valid0;
                gnt1 = valid1;
            end
        end
        if (gnt0) begin
            last_grant_d = GNT_ALU;
        end else if (gnt1) begin
            last_grant_d = GNT_MEM;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GNT_ALU;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and load writeback, with a
// clear sweep that writes CLEAR_VALUE to every register and stalls both.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int                DATA_W      = regfile_write_arbiter_pkg::DATA_W,
    parameter int                ADDR_W      = regfile_write_arbiter_pkg::ADDR_W,
    parameter int                NUM_REGS    = regfile_write_arbiter_pkg::NUM_REGS,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_dest,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_dest,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    output logic              last_grant
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(NUM_REGS - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_dest_q, wr_dest_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic arb_en;
    logic gnt0;
    logic gnt1;

    // Writebacks only compete while idle and no sweep is being launched.
    assign arb_en = (state_q == ST_IDLE) && !clear_start;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .rst        (rst),
        .en         (arb_en),
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .last_grant (last_grant)
    );

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_dest_d = wr_dest_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_start) begin
                    state_d   = ST_CLEAR;
                    cnt_d     = '0;
                    wr_en_d   = 1'b1;
                    wr_dest_d = '0;
                    wr_data_d = CLEAR_VALUE;
                    busy_d    = 1'b1;
                end else if (gnt0) begin
                    wr_en_d   = 1'b1;
                    wr_dest_d = req0_dest;
                    wr_data_d = req0_data;
                end else if (gnt1) begin
                    wr_en_d   = 1'b1;
                    wr_dest_d = req1_dest;
                    wr_data_d = req1_data;
                end
            end
            ST_CLEAR: begin
                // cnt_q is the address being driven on the write port now.
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    wr_en_d   = 1'b1;
                    wr_dest_d = cnt_d[ADDR_W-1:0];
                    wr_data_d = CLEAR_VALUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_dest_q <= wr_dest_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign reg_write_en   = wr_en_q;
    assign reg_write_dest = wr_dest_q;
    assign reg_write_data = wr_data_q;
    assign clear_busy     = busy_q;
    assign clear_done     = done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized bench for regfile_write_arbiter against a
// cycle-level transaction model and a shadow register file.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_dest, req1_dest;
    logic [15:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        clear_start, clear_busy, clear_done;
    logic        reg_write_en;
    logic [3:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic        last_grant;

    regfile_write_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .req0_valid     (req0_valid),
        .req0_dest      (req0_dest),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_dest      (req1_dest),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .clear_start    (clear_start),
        .clear_busy     (clear_busy),
        .clear_done     (clear_done),
        .reg_write_en   (reg_write_en),
        .reg_write_dest (reg_write_dest),
        .reg_write_data (reg_write_data),
        .last_grant     (last_grant)
    );

    always #5 clk = ~clk;

    // Register file fed by the DUT write port.
    logic [15:0] dut_mem [16];
    always @(posedge clk) begin
        if (reg_write_en) dut_mem[reg_write_dest] <= reg_write_data;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Expected outputs for the current cycle, plus expected register contents.
    logic        known    = 1'b0;
    logic        exp_en   = 1'b0;
    logic [3:0]  exp_dest = '0;
    logic [15:0] exp_data = '0;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_last = 1'b0;
    logic [15:0] mdl_mem [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check, advance the model. Entered at posedge+1.
    task automatic cycle(input logic v0, input logic [3:0] d0, input logic [15:0] x0,
                         input logic v1, input logic [3:0] d1, input logic [15:0] x1,
                         input logic cs, input logic r,
                         output logic acc0, output logic acc1);
        logic blocked;
        req0_valid = v0; req0_dest = d0; req0_data = x0;
        req1_valid = v1; req1_dest = d1; req1_data = x1;
        clear_start = cs; rst = r;
        #2;
        if (known) begin
            check("wr_en", 32'(reg_write_en), 32'(exp_en));
            if (exp_en) begin
                check("wr_dest", 32'(reg_write_dest), 32'(exp_dest));
                check("wr_data", 32'(reg_write_data), 32'(exp_data));
            end
            check("clear_busy", 32'(clear_busy), 32'(exp_busy));
            check("clear_done", 32'(clear_done), 32'(exp_done));
            check("last_grant", 32'(last_grant), 32'(exp_last));
        end
        blocked = exp_busy || cs || r;
        acc0 = !blocked && v0 && (!v1 || exp_last == GNT_MEM);
        acc1 = !blocked && v1 && (!v0 || exp_last == GNT_ALU);
        if (known && !r) begin
            check("req0_ready", 32'(req0_ready), 32'(acc0));
            check("req1_ready", 32'(req1_ready), 32'(acc1));
        end
        if (known && exp_en) mdl_mem[exp_dest] = exp_data;

        if (r) begin
            known = 1'b1;
            exp_en = 1'b0; exp_dest = '0; exp_data = '0;
            exp_busy = 1'b0; exp_done = 1'b0; exp_last = GNT_ALU;
        end else if (exp_busy) begin
            exp_done = (exp_dest == 4'd15);
            exp_busy = !exp_done;
            exp_en   = !exp_done;
            if (!exp_done) begin
                exp_dest = exp_dest + 4'd1;
                exp_data = 16'h0000;
            end
        end else if (cs) begin
            exp_en = 1'b1; exp_dest = 4'd0; exp_data = 16'h0000;
            exp_busy = 1'b1; exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            exp_en   = acc0 || acc1;
            if (acc0) begin
                exp_dest = d0; exp_data = x0; exp_last = GNT_ALU;
            end else if (acc1) begin
                exp_dest = d1; exp_data = x1; exp_last = GNT_MEM;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic a0, a1;
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, a0, a1);
    endtask

    task automatic do_reset();
        logic a0, a1;
        cycle(0, 0, 0, 0, 0, 0, 0, 1, a0, a1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, a0, a1);
    endtask

    task automatic compare_mem(input string tag);
        for (int i = 0; i < 16; i++) check(tag, 32'(dut_mem[i]), 32'(mdl_mem[i]));
    endtask

    initial begin
        logic a0, a1;
        int stalls, busy_cnt, done_cnt, wr_cnt;
        logic        p0v, p1v;
        logic [3:0]  p0d, p1d;
        logic [15:0] p0x, p1x;

        @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // Single ALU write; expect write in the next cycle only.
        cycle(1, 4'd2, 16'h0666, 0, 0, 0, 0, 0, a0, a1);
        check("t1_accept", 32'(a0), 32'd1);
        idle(2);

        // Contention after reset: load wins first, then ALU.
        do_reset();
        cycle(1, 4'd3, 16'h1111, 1, 4'd4, 16'h2222, 0, 0, a0, a1);
        check("t2_first_mem", 32'(a1), 32'd1);
        cycle(1, 4'd3, 16'h1111, 1, 4'd4, 16'h2222, 0, 0, a0, a1);
        check("t2_second_alu", 32'(a0), 32'd1);
        idle(2);

        // Same destination: the later grant (ALU) holds the final value.
        do_reset();
        cycle(1, 4'd5, 16'hAAAA, 1, 4'd5, 16'hBBBB, 0, 0, a0, a1);
        cycle(1, 4'd5, 16'hAAAA, 0, 4'd5, 16'hBBBB, 0, 0, a0, a1);
        idle(2);
        check("t3_rf5", 32'(dut_mem[5]), 32'h0000AAAA);

        // Clear with ALU waiting: 17 stalled cycles, 16 busy, one done.
        stalls = 0; busy_cnt = 0; done_cnt = 0;
        cycle(1, 4'd7, 16'h7777, 0, 0, 0, 1, 0, a0, a1);
        for (int i = 0; i < 40 && !a0; i++) begin
            stalls++;
            busy_cnt += int'(clear_busy);
            done_cnt += int'(clear_done);
            cycle(1, 4'd7, 16'h7777, 0, 0, 0, 0, 0, a0, a1);
        end
        check("t4_stalls", 32'(stalls), 32'd17);
        check("t4_busy_cycles", 32'(busy_cnt), 32'd16);
        check("t4_done_pulses", 32'(done_cnt), 32'd1);
        idle(2);
        mdl_mem[7] = 16'h7777;
        check("t4_rf7", 32'(dut_mem[7]), 32'h00007777);
        for (int i = 0; i < 16; i++) if (i != 7) check("t4_rf_clear", 32'(dut_mem[i]), 32'd0);

        // Fill registers, then reset on the dest=5 sweep write.
        for (int i = 0; i < 16; i++)
            cycle(0, 0, 0, 1, 4'(i), 16'($urandom_range(1, 16'hFFFF)), 0, 0, a0, a1);
        idle(1);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, a0, a1);
        idle(5);
        check("t5_dest_at_rst", 32'(reg_write_dest), 32'd5);
        cycle(0, 0, 0, 0, 0, 0, 0, 1, a0, a1);
        idle(20);
        compare_mem("t5_rf_after_abort");

        // A second clear_start during the sweep is ignored.
        wr_cnt = 0; done_cnt = 0;
        cycle(0, 0, 0, 0, 0, 0, 1, 0, a0, a1);
        for (int i = 0; i < 24; i++) begin
            wr_cnt   += int'(reg_write_en);
            done_cnt += int'(clear_done);
            cycle(0, 0, 0, 0, 0, 0, (i == 4), 0, a0, a1);
        end
        check("t6_sweep_writes", 32'(wr_cnt), 32'd16);
        check("t6_done_pulses", 32'(done_cnt), 32'd1);

        // Random traffic; requesters hold dest/data until accepted.
        p0v = 0; p1v = 0; p0d = 0; p1d = 0; p0x = 0; p1x = 0;
        for (int i = 0; i < 600; i++) begin
            if (!p0v && $urandom_range(0, 2) != 0) begin
                p0v = 1; p0d = 4'($urandom); p0x = 16'($urandom);
            end
            if (!p1v && $urandom_range(0, 2) != 0) begin
                p1v = 1; p1d = 4'($urandom); p1x = 16'($urandom);
            end
            cycle(p0v, p0d, p0x, p1v, p1d, p1x,
                  ($urandom_range(0, 59) == 0), ($urandom_range(0, 199) == 0), a0, a1);
            if (a0) p0v = 0;
            if (a1) p1v = 0;
        end
        idle(20);
        compare_mem("rand_rf");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
